// File: rtl/riscv_llwb_arb_pkg.sv
// Shared constants for the long-latency writeback arbiter: channel assignments,
// default FIFO depth and the round-robin pointer advance rule.
package riscv_llwb_arb_pkg;

    localparam int LLWB_CH_DMEM    = 0;
    localparam int LLWB_CH_MUL     = 1;
    localparam int LLWB_CH_DIV     = 2;
    localparam int LLWB_CH_FPU     = 3;
    localparam int LLWB_DEF_QDEPTH = 2;

    // Channel 0 is outside the rotation, so the pointer wraps back to 1.
    function automatic int llwb_rr_next(input int k, input int num_ch);
        return (k >= num_ch - 1) ? 1 : k + 1;
    endfunction

endpackage

// File: rtl/riscv_llwb_arb_if.sv
// Producer-side and register-file-side handshake bundle of the long-latency
// writeback arbiter; the arbiter connects through the slave modport.
interface riscv_llwb_arb_if #(
    parameter int NUM_CH = 4,
    parameter int XLEN   = 64,
    parameter int TAGW   = 5
);
    localparam int CHW = $clog2(NUM_CH);

    logic [NUM_CH-1:0]      in_val;
    logic [NUM_CH-1:0]      in_rdy;
    logic [NUM_CH*XLEN-1:0] in_data;
    logic [NUM_CH*TAGW-1:0] in_tag;
    logic                   wb_val;
    logic                   wb_rdy;
    logic [TAGW-1:0]        wb_waddr;
    logic [XLEN-1:0]        wb_wdata;
    logic [CHW-1:0]         wb_src;

    modport master (
        output in_val, in_data, in_tag, wb_rdy,
        input  in_rdy, wb_val, wb_waddr, wb_wdata, wb_src
    );

    modport slave (
        input  in_val, in_data, in_tag, wb_rdy,
        output in_rdy, wb_val, wb_waddr, wb_wdata, wb_src
    );

endinterface

// File: rtl/riscv_llwb_fifo.sv
// Per-channel result FIFO with a separate occupancy counter; rdy is the
// registered not-full indication, low while reset is applied.
module riscv_llwb_fifo #(
    parameter int W     = 69,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enq,
    input  logic [W-1:0] enq_data,
    input  logic         deq,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty,
    output logic         rdy
);
    localparam int            PW      = $clog2(DEPTH);
    localparam logic [PW:0]   DEPTH_C = (PW + 1)'(DEPTH);
    localparam logic [PW:0]   ONE_C   = (PW + 1)'(1);
    localparam logic [PW-1:0] PSTEP_C = PW'(1);

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [PW:0]   cnt_r;
    logic [PW:0]   cnt_nxt_s;
    logic          rdy_r;
    logic          do_enq_s;
    logic          do_deq_s;

    assign full  = (cnt_r == DEPTH_C);
    assign empty = (cnt_r == {(PW + 1){1'b0}});
    assign head  = mem_r[rd_ptr_r];
    assign rdy   = rdy_r;

    // Qualified push/pop and next occupancy.
    always_comb begin
        do_enq_s  = enq & ~full;
        do_deq_s  = deq & ~empty;
        cnt_nxt_s = cnt_r;
        if (do_enq_s && !do_deq_s) begin
            cnt_nxt_s = cnt_r + ONE_C;
        end else if (!do_enq_s && do_deq_s) begin
            cnt_nxt_s = cnt_r - ONE_C;
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Pointers, occupancy, registered ready and storage.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            cnt_r    <= {(PW + 1){1'b0}};
            rdy_r    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {W{1'b0}};
            end
        end else begin
            cnt_r <= cnt_nxt_s;
            rdy_r <= (cnt_nxt_s != DEPTH_C);
            if (do_enq_s) begin
                mem_r[wr_ptr_r] <= enq_data;
                wr_ptr_r        <= wr_ptr_r + PSTEP_C;
            end
            if (do_deq_s) begin
                rd_ptr_r <= rd_ptr_r + PSTEP_C;
            end
        end
    end

endmodule

// File: rtl/riscv_llwb_arb.sv
// Long-latency writeback arbiter: channel 0 has absolute priority, the rest are
// served round-robin. Define RISCV_LLWB_BYPASS_EN for a 0-cycle empty-FIFO bypass.
module riscv_llwb_arb
    import riscv_llwb_arb_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int XLEN   = 64,
    parameter int TAGW   = 5,
    parameter int QDEPTH = LLWB_DEF_QDEPTH
) (
    input  logic             clk,
    input  logic             reset,
    riscv_llwb_arb_if.slave  bus,
    output logic             ovf_err
);
    localparam int             CHW      = $clog2(NUM_CH);
    localparam int             EW       = TAGW + XLEN;
    localparam logic [CHW-1:0] RR_FIRST = CHW'(1);
    localparam logic [CHW-1:0] CH_DMEM  = CHW'(LLWB_CH_DMEM);

    logic [EW-1:0]     head_s   [NUM_CH];
    logic [EW-1:0]     in_ent_s [NUM_CH];
    logic [NUM_CH-1:0] full_s;
    logic [NUM_CH-1:0] empty_s;
    logic [NUM_CH-1:0] fifo_rdy_s;
    logic [NUM_CH-1:0] enq_s;
    logic [NUM_CH-1:0] deq_s;
    logic [NUM_CH-1:0] byp_v_s;
    logic [NUM_CH-1:0] cand_s;
    logic [CHW-1:0]    gnt_s;
    logic [CHW-1:0]    idx_s;
    logic              hit_s;
    logic              wb_val_s;
    logic              fire_s;
    logic [EW-1:0]     gnt_ent_s;
    logic [CHW-1:0]    rr_ptr_r;
    logic [CHW-1:0]    held_r;
    logic              lock_r;
    logic              ovf_err_r;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign in_ent_s[k] = {bus.in_tag[k*TAGW +: TAGW], bus.in_data[k*XLEN +: XLEN]};

        riscv_llwb_fifo #(
            .W     (EW),
            .DEPTH (QDEPTH)
        ) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .enq      (enq_s[k]),
            .enq_data (in_ent_s[k]),
            .deq      (deq_s[k]),
            .head     (head_s[k]),
            .full     (full_s[k]),
            .empty    (empty_s[k]),
            .rdy      (fifo_rdy_s[k])
        );
    end

    assign bus.in_rdy = fifo_rdy_s;

`ifdef RISCV_LLWB_BYPASS_EN
    assign byp_v_s = bus.in_val & empty_s;
`else
    assign byp_v_s = {NUM_CH{1'b0}};
`endif
    assign cand_s = ~empty_s | byp_v_s;

    // Grant selection; a stalled output keeps its previous grant.
    always_comb begin
        gnt_s = {CHW{1'b0}};
        hit_s = 1'b0;
        idx_s = {CHW{1'b0}};
        if (lock_r) begin
            gnt_s = held_r;
            hit_s = 1'b1;
        end else if (cand_s[CH_DMEM]) begin
            gnt_s = CH_DMEM;
            hit_s = 1'b1;
        end else begin
            for (int i = 0; i < NUM_CH - 1; i++) begin
                idx_s = CHW'(((int'(rr_ptr_r) - 1 + i) % (NUM_CH - 1)) + 1);
                if (!hit_s && cand_s[idx_s]) begin
                    gnt_s = idx_s;
                    hit_s = 1'b1;
                end else begin
                    hit_s = hit_s;
                end
            end
        end
    end

    // Output entry from the granted FIFO head or, with bypass, the live beat.
    always_comb begin
        gnt_ent_s = head_s[gnt_s];
`ifdef RISCV_LLWB_BYPASS_EN
        if (byp_v_s[gnt_s]) begin
            gnt_ent_s = in_ent_s[gnt_s];
        end else begin
            gnt_ent_s = head_s[gnt_s];
        end
`endif
    end

    assign wb_val_s     = hit_s & ~reset;
    assign fire_s       = wb_val_s & bus.wb_rdy;
    assign bus.wb_val   = wb_val_s;
    assign bus.wb_waddr = gnt_ent_s[EW-1 -: TAGW];
    assign bus.wb_wdata = gnt_ent_s[XLEN-1:0];
    assign bus.wb_src   = gnt_s;

    // Per-channel push/pop; a bypassed beat consumed this cycle is never stored.
    always_comb begin
        enq_s = {NUM_CH{1'b0}};
        deq_s = {NUM_CH{1'b0}};
        for (int k = 0; k < NUM_CH; k++) begin
            deq_s[k] = fire_s & (gnt_s == CHW'(k)) & ~empty_s[k];
            enq_s[k] = bus.in_val[k] & ~full_s[k]
                     & ~(fire_s & (gnt_s == CHW'(k)) & byp_v_s[k]);
        end
    end

    // Round-robin pointer, stall lock and sticky overflow flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_r  <= RR_FIRST;
            held_r    <= {CHW{1'b0}};
            lock_r    <= 1'b0;
            ovf_err_r <= 1'b0;
        end else begin
            lock_r    <= wb_val_s & ~bus.wb_rdy;
            held_r    <= gnt_s;
            ovf_err_r <= ovf_err_r | (|(bus.in_val & full_s));
            if (fire_s && (gnt_s != CH_DMEM)) begin
                rr_ptr_r <= CHW'(llwb_rr_next(int'(gnt_s), NUM_CH));
            end
        end
    end

    assign ovf_err = ovf_err_r;

endmodule

// File: tb/tb_riscv_llwb_arb.sv
// Scoreboard bench for riscv_llwb_arb: a queue-based reference model predicts
// every cycle's writeback, ready and overflow state; a monitor checks them.
module tb_riscv_llwb_arb;
    localparam int NUM_CH = 4;
    localparam int XLEN   = 64;
    localparam int TAGW   = 5;
    localparam int QDEPTH = 2;
    localparam int EW     = TAGW + XLEN;

    typedef logic [EW-1:0] ent_t;

    typedef struct {
        logic              chk_full;
        logic              val;
        int                src;
        ent_t              ent;
        logic [NUM_CH-1:0] rdy;
        logic              ovf;
    } rec_t;

    logic clk = 1'b0;
    logic reset;
    logic ovf_err;

    int checks = 0;
    int errors = 0;

    ent_t mq [NUM_CH][$];
    rec_t sb [$];
    int   rr_m;
    int   lock_m;
    logic ovf_m;
    logic post_rst_m;

    riscv_llwb_arb_if #(.NUM_CH(NUM_CH), .XLEN(XLEN), .TAGW(TAGW)) bus ();

    riscv_llwb_arb #(
        .NUM_CH (NUM_CH),
        .XLEN   (XLEN),
        .TAGW   (TAGW),
        .QDEPTH (QDEPTH)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .ovf_err (ovf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Priority channel first, then scan upward from rr_m and wrap to channel 1.
    function automatic int arb();
        if (mq[0].size() > 0) return 0;
        for (int k = rr_m; k < NUM_CH; k++) if (mq[k].size() > 0) return k;
        for (int k = 1; k < rr_m; k++) if (mq[k].size() > 0) return k;
        return -1;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < NUM_CH; k++) mq[k].delete();
        rr_m       = 1;
        lock_m     = -1;
        ovf_m      = 1'b0;
        post_rst_m = 1'b1;
    endtask

    task automatic do_reset();
        rec_t r;
        reset       = 1'b1;
        bus.in_val  = '0;
        r.chk_full  = 1'b0;
        r.val       = 1'b0;
        r.src       = 0;
        r.ent       = '0;
        r.rdy       = '0;
        r.ovf       = 1'b0;
        sb.push_back(r);
        model_clear();
        @(posedge clk); #1;
    endtask

    task automatic step(input logic [NUM_CH-1:0] v_in, input logic rdy,
                        input int fix_ch, input ent_t fix_ent);
        logic [NUM_CH-1:0] v;
        logic [NUM_CH-1:0] pushed;
        ent_t              beat [NUM_CH];
        int                sz   [NUM_CH];
        int                pres;
        rec_t              r;
        v      = v_in;
        pushed = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            beat[k] = (k == fix_ch) ? fix_ent
                    : {TAGW'($urandom_range(0, 31)), $urandom, $urandom};
            sz[k] = mq[k].size();
            if (k != 0 && sz[k] >= QDEPTH) v[k] = 1'b0;
        end
        if (post_rst_m) v = '0;
        reset      = 1'b0;
        bus.in_val = v;
        bus.wb_rdy = rdy;
        for (int k = 0; k < NUM_CH; k++) begin
            bus.in_data[k*XLEN +: XLEN] = beat[k][XLEN-1:0];
            bus.in_tag[k*TAGW +: TAGW]  = beat[k][XLEN +: TAGW];
        end
        r.chk_full = 1'b1;
        r.ovf      = ovf_m;
        for (int k = 0; k < NUM_CH; k++) r.rdy[k] = !post_rst_m && (sz[k] < QDEPTH);
`ifdef RISCV_LLWB_BYPASS_EN
        for (int k = 0; k < NUM_CH; k++) begin
            if (v[k] && sz[k] == 0) begin
                mq[k].push_back(beat[k]);
                pushed[k] = 1'b1;
            end
        end
`endif
        pres  = (lock_m >= 0) ? lock_m : arb();
        r.val = (pres >= 0);
        r.src = pres;
        r.ent = (pres >= 0) ? mq[pres][0] : '0;
        if (pres >= 0 && rdy) begin
            void'(mq[pres].pop_front());
            if (pres != 0) rr_m = (pres == NUM_CH - 1) ? 1 : pres + 1;
            lock_m = -1;
        end else begin
            lock_m = pres;
        end
        for (int k = 0; k < NUM_CH; k++) begin
            if (v[k] && !pushed[k]) begin
                if (sz[k] < QDEPTH) mq[k].push_back(beat[k]);
                else ovf_m = 1'b1;
            end
        end
        post_rst_m = 1'b0;
        sb.push_back(r);
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step('0, rdy, -1, '0);
    endtask

    // Monitor: compare the DUT against the expected record for this cycle.
    rec_t mr;
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mr = sb.pop_front();
            chk("wb_val", 64'(bus.wb_val), 64'(mr.val));
            if (mr.chk_full) begin
                chk("in_rdy", 64'(bus.in_rdy), 64'(mr.rdy));
                chk("ovf_err", 64'(ovf_err), 64'(mr.ovf));
            end
            if (mr.val && bus.wb_val) begin
                chk("wb_src", 64'(bus.wb_src), 64'(mr.src));
                chk("wb_waddr", 64'(bus.wb_waddr), 64'(mr.ent[XLEN +: TAGW]));
                chk("wb_wdata", bus.wb_wdata, mr.ent[XLEN-1:0]);
            end
        end
    end

    initial begin
        reset       = 1'b1;
        bus.in_val  = '0;
        bus.in_data = '0;
        bus.in_tag  = '0;
        bus.wb_rdy  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_clear();

        idle(9, 1'b1);
        // Single beat on channel 2.
        step(4'b0100, 1'b1, 2, {5'd5, 64'hDEAD});
        idle(3, 1'b1);
        // Channels 0, 1 and 3 together.
        step(4'b1011, 1'b1, -1, '0);
        idle(4, 1'b1);
        // Channels 1..3 backlogged.
        for (int i = 0; i < 14; i++) step(4'b1110, 1'b1, -1, '0);
        idle(4, 1'b1);
        // Backpressure on channel 1.
        for (int i = 0; i < 3; i++) step(4'b0010, 1'b0, -1, '0);
        idle(2, 1'b0);
        idle(4, 1'b1);
        // Channel 0 overflow while stalled.
        for (int i = 0; i < 3; i++) step(4'b0001, 1'b0, -1, '0);
        idle(1, 1'b0);
        idle(4, 1'b1);
        // Reset with entries queued in channels 1 and 2.
        step(4'b0110, 1'b0, -1, '0);
        step(4'b0110, 1'b0, -1, '0);
        do_reset();
        idle(3, 1'b1);
        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            logic [NUM_CH-1:0] v;
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                for (int k = 0; k < NUM_CH; k++) v[k] = ($urandom_range(0, 99) < 35);
                step(v, ($urandom_range(0, 99) < 70), -1, '0);
            end
        end
        idle(8, 1'b1);
        chk("sb_drain", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/riscv_llwb_arb.md
Name: riscv_llwb_arb

Overview:
- Parametrised long-latency writeback arbiter.
- Merges NUM_CH result producers (dmem response, mul, div, FPU-to-int, future coprocessors) into the single long-latency register-file write port (waddr/wen/wdata) consumed by datapath and control.
- Each channel gets its own small FIFO so producers never collide.
- Arbitration: channel 0 (dmem) has absolute priority; channels 1..NUM_CH-1 are served round-robin.

Parameters:
- NUM_CH, 4, number of producer channels (2..8); channel 0 is the priority channel.
- XLEN, 64, result data width.
- TAGW, 5, destination register tag width.
- QDEPTH, 2, entries per channel FIFO (power of two, >=2).
- CHW, $clog2(NUM_CH), width of the source-channel index (derived, not overridable).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_val  in  NUM_CH  per-channel result valid
- in_rdy  out  NUM_CH  per-channel FIFO not full (registered)
- in_data  in  NUM_CH*XLEN  packed results; channel k at [k*XLEN +: XLEN]
- in_tag  in  NUM_CH*TAGW  packed destination tags
- wb_val  out  1  writeback valid (ll_wen)
- wb_rdy  in  1  register-file port available this cycle
- wb_waddr  out  TAGW  destination register
- wb_wdata  out  XLEN  result data
- wb_src  out  CHW  index of the granted channel
- ovf_err  out  1  sticky overflow flag

Behaviour:
- Reset: all FIFOs empty, rr_ptr=1, ovf_err=0. wb_val=0, in_rdy=all ones from the cycle after reset deasserts; in_rdy=0 while reset is high.
- Enqueue: on in_val[k] & in_rdy[k], the {tag,data} pair is written at channel k's tail.
- in_rdy[k] = !full[k] only. There is no same-cycle full-with-dequeue pass-through.
- Overflow: in_val[k] while full[k] drops the beat and sets ovf_err. ovf_err clears only on reset. This case arises only from channel 0, since dmem ignores rdy.
- Output: wb_val = OR of non-empty channels. wb_waddr, wb_wdata and wb_src come from the head of the granted channel, combinationally.
- Grant rules:
  - If channel 0 is non-empty, grant channel 0.
  - Otherwise grant the first non-empty channel starting at rr_ptr, scanning upward and wrapping NUM_CH-1 -> 1.
- Dequeue: occurs only when wb_val & wb_rdy. After a round-robin grant to channel k, rr_ptr <= (k==NUM_CH-1) ? 1 : k+1. A channel-0 grant does not move rr_ptr.
- wb_rdy=0 holds the grant and all outputs stable; the arbiter never re-arbitrates while the output is stalled.
- Latency: 1 cycle minimum (enqueue at t, wb_val at t+1) when the bypass feature is absent.
- Simultaneous enqueue and dequeue on the same channel: occupancy unchanged, ordering preserved.
- FIFO pointers wrap modulo QDEPTH. Occupancy is a separate log2(QDEPTH)+1-bit counter.
- Reset asserted mid-operation discards all queued entries. No writeback is issued on the reset cycle.

Optional Feature:
- Macro: RISCV_LLWB_BYPASS_EN.
- When defined, the bypass applies if a channel's FIFO is empty, in_val[k]=1, and k would win arbitration this cycle (treating the incoming beat as its head).
  - The beat drives wb_* combinationally in the same cycle (0-cycle latency).
  - If wb_rdy=1, the beat is not written into the FIFO.
  - If wb_rdy=0, the beat is enqueued normally.
- When undefined, every beat passes through its FIFO (1-cycle minimum latency). No combinational path exists from in_* to wb_*.

Decomposition:
- Shared package/header `riscvLlwbConst.vh`: LLWB_CH_DMEM=0, LLWB_CH_MUL=1, LLWB_CH_DIV=2, LLWB_CH_FPU=3, default depth constant.
- One sub-module: riscv_llwb_fifo (per-channel XLEN+TAGW-wide, QDEPTH-entry FIFO exposing full, empty, head, enq, deq), instantiated NUM_CH times in a generate loop.
- Arbiter, rr_ptr and the overflow flag stay in the top module.

Test Plan:
- Single beat, latency: ch2 sends tag=5, data=0xDEAD at cycle 10 with wb_rdy=1 -> wb_val=1 at cycle 11 with waddr=5, wdata=0xDEAD, src=2; with RISCV_LLWB_BYPASS_EN, the same appears at cycle 10.
- Channel-0 priority: ch0, ch1 and ch3 all valid in the same cycle, wb_rdy=1 -> grants ch0, then ch1, then ch3 on consecutive cycles; rr_ptr=1 after ch3 (wrap).
- Round-robin fairness: ch1, ch2 and ch3 continuously backlogged, ch0 idle -> grant order 1,2,3,1,2,3; each channel gets 4 grants in 12 cycles.
- Backpressure: wb_rdy=0 for 5 cycles while ch1 sends 3 beats (QDEPTH=2) -> in_rdy[1]=0 after 2 beats, wb_* held constant throughout; beats then drain in order once wb_rdy=1.
- Overflow: ch0 sends 3 beats with wb_rdy=0 (QDEPTH=2) -> third beat dropped, ovf_err=1 and stays 1 until reset; the first two beats drain correctly.
- Reset mid-run: assert reset with 2 entries queued in ch1 and ch2 -> next cycle wb_val=0, all FIFOs empty, ovf_err=0, in_rdy=0 during reset and all ones after.
